// File: rtl/f1_pkg.sv
// Shared constants for the f1 gate unit: common truth tables and the sync-depth limit.
// The truth-table helper keeps the {a,b} index ordering in one place.
package f1_pkg;

    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_XNOR  = 4'b1001;

    localparam int SYNC_MAX = 3;

    // a is the index MSB, b the LSB
    function automatic logic tt_lookup(input logic [3:0] tt, input logic a, input logic b);
        return tt[{a, b}];
    endfunction

endpackage

// File: rtl/f1_sync_chain.sv
// Parameterized 1-bit flop chain with synchronous active-high reset.
// Used only for STAGES >= 1; the zero-stage case is a wire in the parent.
module f1_sync_chain #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_r;
    logic [STAGES:0]   chain_s;

    assign chain_s = {stage_r, d};
    assign q       = chain_s[STAGES];

    // Shift the input one stage per clock; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= {STAGES{1'b0}};
        end else begin
            stage_r <= chain_s[STAGES-1:0];
        end
    end

endmodule

// File: rtl/f1_gate_unit.sv
// Clocked two-input boolean function unit: o = TT[{i1,i2}] after optional sync stages.
// Optional output-activity counter enabled by defining F1_ACT_CNT_EN.
module f1_gate_unit
    import f1_pkg::*;
#(
    parameter logic [3:0] TT          = TT_XOR,
    parameter bit         REG_OUT     = 1'b1,
    parameter int         SYNC_STAGES = 0,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i1,
    input  logic             i2,
    output logic             o,
`ifdef F1_ACT_CNT_EN
    output logic [CNT_W-1:0] act_cnt,
`endif
    output logic             o_chg
);

    logic a_s;
    logic b_s;
    logic f_s;
    logic armed_r;
    logic o_prev_r;
    logic o_chg_r;

    if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("f1_gate_unit: SYNC_STAGES must be in 0..3");
    end

    if (CNT_W < 1) begin : g_bad_cnt
        $error("f1_gate_unit: CNT_W must be at least 1");
    end

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign a_s = i1;
        assign b_s = i2;
    end else begin : g_sync
        f1_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_i1 (
            .clk (clk),
            .rst (rst),
            .d   (i1),
            .q   (a_s)
        );
        f1_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_i2 (
            .clk (clk),
            .rst (rst),
            .d   (i2),
            .q   (b_s)
        );
    end

    assign f_s = tt_lookup(TT, a_s, b_s);

    if (REG_OUT) begin : g_reg_out
        logic o_r;

        // Output register: one cycle of latency after the sync chain.
        always_ff @(posedge clk) begin
            if (rst) begin
                o_r <= 1'b0;
            end else begin
                o_r <= f_s;
            end
        end

        assign o = o_r;
    end else begin : g_comb_out
        assign o = f_s;
    end

    // Change detector. armed_r masks the first edge after reset so a combinational
    // output that differs from the cleared o_prev_r is not reported as a transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_r  <= 1'b0;
            o_prev_r <= 1'b0;
            o_chg_r  <= 1'b0;
        end else begin
            armed_r  <= 1'b1;
            o_prev_r <= o;
            o_chg_r  <= armed_r & (o ^ o_prev_r);
        end
    end

    assign o_chg = o_chg_r;

`ifdef F1_ACT_CNT_EN
    logic [CNT_W-1:0] act_cnt_r;

    // Saturating count of output transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_cnt_r <= {CNT_W{1'b0}};
        end else if (o_chg_r && (act_cnt_r != {CNT_W{1'b1}})) begin
            act_cnt_r <= act_cnt_r + CNT_W'(1'b1);
        end else begin
            act_cnt_r <= act_cnt_r;
        end
    end

    assign act_cnt = act_cnt_r;
`endif

endmodule

// File: tb/tb_f1_gate_unit.sv
// Scoreboard bench: five configurations of f1_gate_unit share one randomized input stream.
// Expected responses come from an input-history reference model.
`timescale 1ns/1ps
module tb_f1_gate_unit;
    import f1_pkg::*;

    localparam int ND = 5;
    localparam int NC = 400;
    localparam int CW = 2;

    localparam logic [3:0] TTS  [ND] = '{TT_XOR, TT_AND, TT_OR, TT_NAND, TT_NOR};
    localparam bit         REGS [ND] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam int         SS   [ND] = '{0, 2, 0, 3, 1};

    // Directed prefix: {rst, i1, i2} and hold length in cycles
    localparam int ND_DIR = 9;
    localparam logic [2:0] DIR_V [ND_DIR] = '{3'b100, 3'b010, 3'b011, 3'b000, 3'b001,
                                              3'b110, 3'b010, 3'b011, 3'b001};
    localparam int         DIR_L [ND_DIR] = '{3, 5, 5, 5, 5, 3, 6, 6, 6};

    typedef struct packed {
        logic [ND-1:0]         o;
        logic [ND-1:0]         chg;
        logic [ND-1:0][CW-1:0] cnt;
        int                    n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i1  = 1'b0;
    logic i2  = 1'b0;
    logic [ND-1:0] o_w;
    logic [ND-1:0] chg_w;
`ifdef F1_ACT_CNT_EN
    logic [CW-1:0] cnt_w [ND];
`endif

    exp_t sb_q[$];
    int   nvec = 0;
    int   nerr = 0;

    logic [1:0] v_h  [NC];
    bit         r_h  [NC];
    bit         eo_h [ND][NC];
    bit         op_h [ND][NC];
    bit         ch_h [ND][NC];
    int         ct_h [ND][NC];

    always #5 clk = ~clk;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        f1_gate_unit #(
            .TT          (TTS[k]),
            .REG_OUT     (REGS[k]),
            .SYNC_STAGES (SS[k]),
            .CNT_W       (CW)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .i1      (i1),
            .i2      (i2),
            .o       (o_w[k]),
`ifdef F1_ACT_CNT_EN
            .act_cnt (cnt_w[k]),
`endif
            .o_chg   (chg_w[k])
        );
    end

    // Edges before the first tracked one were reset edges with inputs at 0.
    function automatic bit rst_at(input int m);
        return (m < 0) ? 1'b1 : r_h[m];
    endfunction

    function automatic logic [1:0] vin(input int m);
        return (m < 0) ? 2'b00 : v_h[m];
    endfunction

    // Value visible at the end of an s-stage chain after edge m (s >= 1).
    function automatic logic [1:0] ein(input int m, input int s);
        for (int j = m - s + 1; j <= m; j++) begin
            if (rst_at(j)) return 2'b00;
        end
        return vin(m - s + 1);
    endfunction

    function automatic bit lut(input logic [3:0] tt, input logic [1:0] idx);
        return tt[idx];
    endfunction

    // Reference model for edge n: fills the history arrays and queues the expectation.
    task automatic model(input int n);
        exp_t e;
        e.n = n;
        for (int k = 0; k < ND; k++) begin
            bit ov, op, ch, pc;
            int ct, pcnt;
            if (REGS[k]) begin
                if (rst_at(n))       ov = 1'b0;
                else if (SS[k] == 0) ov = lut(TTS[k], vin(n));
                else                 ov = lut(TTS[k], ein(n - 1, SS[k]));
            end else begin
                if (SS[k] == 0)      ov = lut(TTS[k], vin(n));
                else                 ov = lut(TTS[k], ein(n, SS[k]));
            end
            // Output value just before edge n; a combinational zero-stage output already sees the new input.
            if (REGS[k] || SS[k] > 0) op = (n > 0) ? eo_h[k][n-1] : 1'b0;
            else                      op = lut(TTS[k], vin(n));
            ch   = !rst_at(n) && !rst_at(n - 1) && (op != ((n > 0) ? op_h[k][n-1] : 1'b0));
            pc   = (n > 0) ? ch_h[k][n-1] : 1'b0;
            pcnt = (n > 0) ? ct_h[k][n-1] : 0;
            if (rst_at(n))                     ct = 0;
            else if (pc && pcnt < (1 << CW) - 1) ct = pcnt + 1;
            else                               ct = pcnt;
            eo_h[k][n] = ov;
            op_h[k][n] = op;
            ch_h[k][n] = ch;
            ct_h[k][n] = ct;
            e.o[k]   = ov;
            e.chg[k] = ch;
            e.cnt[k] = CW'(ct);
        end
        sb_q.push_back(e);
    endtask

    task automatic step(input bit rr, input logic [1:0] vv, input int n);
        @(negedge clk);
        rst = rr;
        i1  = vv[1];
        i2  = vv[0];
        r_h[n] = rr;
        v_h[n] = vv;
        model(n);
    endtask

    // Stimulus: directed prefix, then random held inputs with occasional single-cycle resets.
    initial begin
        int n;
        n = 0;
        for (int t = 0; t < ND_DIR; t++) begin
            for (int c = 0; c < DIR_L[t]; c++) begin
                step(DIR_V[t][2], DIR_V[t][1:0], n);
                n++;
            end
        end
        while (n < NC) begin
            int         hold;
            bit         rr;
            logic [1:0] vv;
            hold = int'($urandom_range(1, 4));
            rr   = ($urandom_range(0, 39) == 0);
            vv   = 2'($urandom_range(0, 3));
            for (int c = 0; c < hold && n < NC; c++) begin
                step(rr && (c == 0), vv, n);
                n++;
            end
        end
    end

    // Monitor: one sample per edge, mid high phase, compared against the queue head.
    initial begin
        exp_t e;
        @(negedge clk);
        for (int s = 0; s < NC; s++) begin
            @(posedge clk);
            #2;
            if (sb_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL sb_underflow sample %0d: queue size 0, required > 0", s);
            end else begin
                e = sb_q.pop_front();
                for (int k = 0; k < ND; k++) begin
                    nvec++;
                    if (o_w[k] !== e.o[k]) begin
                        nerr++;
                        $display("FAIL o[dut%0d] edge %0d: got %b, want %b", k, e.n, o_w[k], e.o[k]);
                    end
                    nvec++;
                    if (chg_w[k] !== e.chg[k]) begin
                        nerr++;
                        $display("FAIL o_chg[dut%0d] edge %0d: got %b, want %b", k, e.n, chg_w[k], e.chg[k]);
                    end
`ifdef F1_ACT_CNT_EN
                    nvec++;
                    if (cnt_w[k] !== e.cnt[k]) begin
                        nerr++;
                        $display("FAIL act_cnt[dut%0d] edge %0d: got %0d, want %0d", k, e.n, cnt_w[k], e.cnt[k]);
                    end
`endif
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/f1_gate_unit.md
Name: f1_gate_unit

Overview:
- Clocked two-input boolean function unit. The function is set by a 4-bit truth-table parameter; the default is XOR.
- Leaf block in the Experiment-1 logic lab datapath. Benches drive i1/i2 and observe o.
- Optional synchronizer stages on the inputs and an optional output-activity counter.

Parameters:
- TT, 4'b0110, truth table; o = TT[{i1,i2}] (index 0 = i1=0,i2=0; index 3 = i1=1,i2=1).
- REG_OUT, 1, 1 = output registered (1-cycle latency); 0 = o is combinational from the (synchronized) inputs.
- SYNC_STAGES, 0, number of flop stages (0..3) on i1/i2 before evaluation; values >3 are rejected at elaboration.
- CNT_W, 16, width of activity counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  reset; one clock; synchronous, active-high.
- i1  input  1  operand A (MSB of truth-table index).
- i2  input  1  operand B (LSB of truth-table index).
- o  output  1  function result.
- o_chg  output  1  one-cycle pulse when o changes value (registered).

Behaviour:
- Sync stages: each stage resets to 0. Effective inputs a = i1 and b = i2 after SYNC_STAGES flops.
- Evaluation: f = TT[{a,b}], purely combinational lookup.
- REG_OUT=1:
  - o_q <= f each clk; o = o_q.
  - Total latency from i1/i2 to o = SYNC_STAGES+1 cycles.
- REG_OUT=0: o = f; latency = SYNC_STAGES cycles (0 = combinational).
- o_chg:
  - Registered; o_prev tracks o each cycle; o_chg <= (o != o_prev).
  - Asserts for exactly one cycle per output transition, one cycle after o changes.
  - Never asserts on the first cycle after reset release.
- Reset: while rst=1 at a clk edge, all sync flops, o_q, o_prev and o_chg clear to 0.
  - REG_OUT=1: o = 0 during reset and on the first cycle after reset.
  - REG_OUT=0, SYNC_STAGES=0: o follows inputs even during reset. This is an accepted exception.
- Mid-operation reset: takes effect at the next clk edge and discards any in-flight sync-stage values.
- Input changes between clock edges: only the value at the rising edge matters. No glitch filtering beyond the sync stages.
- X on inputs: no special handling. Verification drives only 0/1.

Optional Feature:
- Macro F1_ACT_CNT_EN.
- Defined:
  - Adds output port act_cnt [CNT_W-1:0].
  - act_cnt increments by 1 on each cycle o_chg=1 and saturates at all-ones (no wrap).
  - Cleared to 0 by rst.
- Undefined:
  - No act_cnt port and no counter logic.
  - All other behaviour is identical.

Decomposition:
- Package f1_pkg holds the truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XNOR=4'b1001, plus the SYNC_MAX=3 constant.
- One sub-module is natural: f1_sync_chain (parameterized 1-bit flop chain with sync reset), instantiated for i1 and i2.
- The lookup, output register, change detector and counter stay in f1_gate_unit.

Test Plan:
- Default params (TT=0110, REG_OUT=1, SYNC_STAGES=0), 10 ns clock, inputs held 50 ns each in the order (1,0),(1,1),(0,0),(0,1) -> o = 1,0,0,1, each valid one clock after the input change.
- o_chg pulses exactly one cycle after each transition of the same sequence: after 1->0 at the (1,1) step, stays 0 at (0,0), after 0->1 at the (0,1) step.
- rst=1 for 3 cycles with i1=1,i2=0 -> o=0 and o_chg=0 throughout. Release -> o=1 one cycle later; o_chg pulses once on the following cycle.
- TT=TT_AND, SYNC_STAGES=2, apply (1,1) -> o=1 exactly 3 cycles later. Apply (0,1) -> o=0 after 3 cycles.
- REG_OUT=0, SYNC_STAGES=0, TT=TT_OR: sweep all four input combinations -> o = 0,1,1,1 for indices 0..3 within the same cycle (no clock needed).
- F1_ACT_CNT_EN defined, CNT_W=2: toggle i1 every 2 cycles with i2=0, XOR default -> act_cnt counts 1,2,3 and then holds at 3. A single-cycle rst mid-sequence -> act_cnt=0.
